// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: one transmitter and one receiver sharing the tck domain.
// Bit timing is tck_freq / baud_rate clocks per bit; the receiver samples mid-bit.
module uart_core #(
  parameter int baud_rate = 9600,
  parameter int tck_freq  = 100_000_000
) (
  input  logic       tck,
  input  logic       reset,
  input  logic       TxEnable,
  input  logic [7:0] TxData,
  output logic       TxD,
  output logic       TxDone,
  input  logic       RxD,
  output logic [7:0] RxData
);

  localparam int CLKS_PER_BIT = tck_freq / baud_rate;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);

  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_state_t;

  tx_state_t       tx_state_r, tx_state_s;
  logic [CW-1:0]   tx_cnt_r, tx_cnt_s;
  logic [2:0]      tx_bit_r, tx_bit_s;
  logic [7:0]      tx_shift_r, tx_shift_s;
  logic            txd_r, txd_s, txdone_r, txdone_s;

  rx_state_t       rx_state_r, rx_state_s;
  logic [CW-1:0]   rx_cnt_r, rx_cnt_s;
  logic [2:0]      rx_bit_r, rx_bit_s;
  logic [7:0]      rx_shift_r, rx_shift_s;
  logic [7:0]      rxdata_r, rxdata_s;
  logic            wait_high_r, wait_high_s;
  logic [1:0]      sync_r;
  logic            rx_line_s;

  assign TxD       = txd_r;
  assign TxDone    = txdone_r;
  assign RxData    = rxdata_r;
  assign rx_line_s = sync_r[1];

  // Transmit next-state: the last stop cycle doubles as an idle slot so held requests run back-to-back.
  always_comb begin
    tx_state_s = tx_state_r;
    tx_cnt_s   = tx_cnt_r + CNT_ONE;
    tx_bit_s   = tx_bit_r;
    tx_shift_s = tx_shift_r;
    txd_s      = txd_r;
    case (tx_state_r)
      TX_IDLE: begin
        tx_cnt_s = CNT_ZERO;
        if (TxEnable) begin
          tx_state_s = TX_START;
          tx_shift_s = TxData;
          tx_bit_s   = 3'd0;
          txd_s      = 1'b0;
        end else begin
          txd_s = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_s   = CNT_ZERO;
          tx_state_s = TX_DATA;
          txd_s      = tx_shift_r[0];
        end else begin
          txd_s = 1'b0;
        end
      end
      TX_DATA: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_s = CNT_ZERO;
          if (tx_bit_r == 3'd7) begin
            tx_state_s = TX_STOP;
            txd_s      = 1'b1;
          end else begin
            tx_bit_s   = tx_bit_r + 3'd1;
            tx_shift_s = {1'b0, tx_shift_r[7:1]};
            txd_s      = tx_shift_r[1];
          end
        end else begin
          txd_s = tx_shift_r[0];
        end
      end
      TX_STOP: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_s = CNT_ZERO;
          if (TxEnable) begin
            tx_state_s = TX_START;
            tx_shift_s = TxData;
            tx_bit_s   = 3'd0;
            txd_s      = 1'b0;
          end else begin
            tx_state_s = TX_IDLE;
            txd_s      = 1'b1;
          end
        end else begin
          txd_s = 1'b1;
        end
      end
      default: begin
        tx_state_s = TX_IDLE;
        tx_cnt_s   = CNT_ZERO;
        txd_s      = 1'b1;
      end
    endcase
    txdone_s = (tx_state_s == TX_STOP) && (tx_cnt_s == BIT_LAST);
  end

  // Transmit state and registered serial outputs.
  always_ff @(posedge tck or negedge reset) begin
    if (!reset) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= CNT_ZERO;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'h00;
      txd_r      <= 1'b1;
      txdone_r   <= 1'b0;
    end else begin
      tx_state_r <= tx_state_s;
      tx_cnt_r   <= tx_cnt_s;
      tx_bit_r   <= tx_bit_s;
      tx_shift_r <= tx_shift_s;
      txd_r      <= txd_s;
      txdone_r   <= txdone_s;
    end
  end

  // Receive next-state: after a bad stop bit the line must go high again before a new start counts.
  always_comb begin
    rx_state_s  = rx_state_r;
    rx_cnt_s    = rx_cnt_r + CNT_ONE;
    rx_bit_s    = rx_bit_r;
    rx_shift_s  = rx_shift_r;
    rxdata_s    = rxdata_r;
    wait_high_s = wait_high_r;
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_s = CNT_ZERO;
        if (wait_high_r) begin
          wait_high_s = !rx_line_s;
        end else if (!rx_line_s) begin
          rx_state_s = RX_START;
        end else begin
          rx_state_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_r == HALF_LAST) begin
          rx_cnt_s   = CNT_ZERO;
          rx_bit_s   = 3'd0;
          rx_state_s = rx_line_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_state_s = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s   = CNT_ZERO;
          rx_shift_s = {rx_line_s, rx_shift_r[7:1]};
          rx_bit_s   = rx_bit_r + 3'd1;
          rx_state_s = (rx_bit_r == 3'd7) ? RX_STOP : RX_DATA;
        end else begin
          rx_state_s = RX_DATA;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s   = CNT_ZERO;
          rx_state_s = RX_IDLE;
          if (rx_line_s) begin
            rxdata_s = rx_shift_r;
          end else begin
            wait_high_s = 1'b1;
          end
        end else begin
          rx_state_s = RX_STOP;
        end
      end
      default: begin
        rx_state_s = RX_IDLE;
        rx_cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Receive state, synchroniser and received-byte register.
  always_ff @(posedge tck or negedge reset) begin
    if (!reset) begin
      sync_r      <= 2'b11;
      rx_state_r  <= RX_IDLE;
      rx_cnt_r    <= CNT_ZERO;
      rx_bit_r    <= 3'd0;
      rx_shift_r  <= 8'h00;
      rxdata_r    <= 8'h00;
      wait_high_r <= 1'b0;
    end else begin
      sync_r      <= {sync_r[0], RxD};
      rx_state_r  <= rx_state_s;
      rx_cnt_r    <= rx_cnt_s;
      rx_bit_r    <= rx_bit_s;
      rx_shift_r  <= rx_shift_s;
      rxdata_r    <= rxdata_s;
      wait_high_r <= wait_high_s;
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core at 16 clocks per bit: a frame-level model checked every cycle,
// plus literal expectations for bit order, pulse spacing and received bytes.
module tb_uart_core;

  localparam int BAUD  = 100_000;
  localparam int FREQ  = 1_600_000;
  localparam int C     = 16;
  localparam int HALF  = 8;
  localparam int FRAME = 10 * C;
  localparam int LAT   = 2 + HALF + 9 * C;

  logic       tck = 1'b0;
  logic       reset = 1'b1;
  logic       TxEnable = 1'b0;
  logic [7:0] TxData = 8'h00;
  logic       TxD, TxDone;
  logic [7:0] RxData;
  logic       loop = 1'b1;
  logic       rxd_drv = 1'b1;
  logic       RxD;

  assign RxD = loop ? TxD : rxd_drv;

  uart_core #(.baud_rate(BAUD), .tck_freq(FREQ)) dut (
    .tck(tck), .reset(reset), .TxEnable(TxEnable), .TxData(TxData),
    .TxD(TxD), .TxDone(TxDone), .RxD(RxD), .RxData(RxData)
  );

  always #5 tck = ~tck;

  typedef struct {logic [7:0] val; int nom;} rx_ev_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  rx_ev_t     pend[$];
  int         done_q[$];
  logic       m_busy = 1'b0;
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] exp_rx = 8'h00;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic exp_txd();
    int idx;
    if (!m_busy) return 1'b1;
    idx = m_t / C;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_byte[idx-1];
  endfunction

  // Frame-level transmitter model: position within a 10-bit frame, restarted when a request is seen.
  initial forever begin
    @(posedge tck);
    cyc++;
    if (!reset) begin
      m_busy = 1'b0;
      m_t    = 0;
    end else if (m_busy && m_t < FRAME - 1) begin
      m_t++;
    end else if (TxEnable) begin
      m_busy = 1'b1;
      m_t    = 0;
      m_byte = TxData;
      if (loop) pend.push_back('{TxData, cyc + LAT});
    end else begin
      m_busy = 1'b0;
    end
  end

  initial forever begin
    @(negedge reset);
    m_busy = 1'b0;
    m_t    = 0;
    exp_rx = 8'h00;
    pend.delete();
  end

  initial forever begin
    @(negedge tck);
    if (!reset) begin
      check("rst_txd", TxD, 1'b1);
      check("rst_txdone", TxDone, 1'b0);
      check("rst_rxdata", RxData, 8'h00);
    end else begin
      check("txd", TxD, exp_txd());
      check("txdone", TxDone, m_busy && (m_t == FRAME - 1));
      if (TxDone) done_q.push_back(cyc);
      while (pend.size() > 0 && cyc > pend[0].nom + 1) begin
        exp_rx = pend[0].val;
        void'(pend.pop_front());
      end
      if (!(pend.size() > 0 && cyc >= pend[0].nom - 1)) check("rxdata", RxData, exp_rx);
    end
  end

  task automatic wait_neg(input int target);
    while (cyc < target) @(negedge tck);
  endtask

  task automatic wait_pos(input int target);
    while (cyc < target) begin
      @(posedge tck);
      #1;
    end
  endtask

  task automatic start_tx(input logic [7:0] d, output int k);
    @(posedge tck);
    #1;
    TxData   = d;
    TxEnable = 1'b1;
    @(posedge tck);
    #1;
    k        = cyc;
    TxEnable = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop);
    @(posedge tck);
    #1;
    rxd_drv = 1'b0;
    if (stop) pend.push_back('{d, cyc + LAT});
    repeat (C) @(posedge tck);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      repeat (C) @(posedge tck);
      #1;
    end
    rxd_drv = stop;
    repeat (C) @(posedge tck);
    #1;
    rxd_drv = 1'b1;
    repeat (2 * C) @(posedge tck);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [9:0] seq;
    seq = 10'b1101001010;

    #1 reset = 1'b0;
    repeat (4) @(posedge tck);
    #1 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge tck);
      check("idle_txd", TxD, 1'b1);
      check("idle_txdone", TxDone, 1'b0);
      check("idle_rxdata", RxData, 8'h00);
    end

    done_q.delete();
    start_tx(8'hA5, k);
    TxData = 8'h00;
    for (int i = 0; i < 10; i++) begin
      wait_neg(k + C / 2 + i * C);
      check("a5_bit", TxD, seq[i]);
    end
    wait_neg(k + FRAME + 2);
    check("a5_rx", RxData, 8'hA5);
    check("a5_done_count", done_q.size(), 1);
    check("a5_done_at", (done_q.size() > 0) ? done_q[0] - k : -1, FRAME - 1);

    done_q.delete();
    @(posedge tck);
    #1;
    TxData   = 8'h00;
    TxEnable = 1'b1;
    @(posedge tck);
    #1;
    k      = cyc;
    TxData = 8'hFF;
    wait_pos(k + FRAME);
    TxEnable = 1'b0;
    @(negedge tck);
    check("b2b_no_gap", TxD, 1'b0);
    wait_neg(k + 2 * FRAME + 2);
    check("b2b_rx", RxData, 8'hFF);
    check("b2b_done_count", done_q.size(), 2);
    check("b2b_done_gap", (done_q.size() > 1) ? done_q[1] - done_q[0] : -1, FRAME);

    loop = 1'b0;
    @(posedge tck);
    #1 rxd_drv = 1'b0;
    repeat (5) @(posedge tck);
    #1 rxd_drv = 1'b1;
    repeat (3 * C) @(posedge tck);
    #1;
    check("glitch_keep", RxData, 8'hFF);
    drive_frame(8'h3C, 1'b1);
    check("after_glitch_rx", RxData, 8'h3C);

    drive_frame(8'h5A, 1'b0);
    check("frame_err_keep", RxData, 8'h3C);
    drive_frame(8'hC3, 1'b1);
    check("after_frame_err_rx", RxData, 8'hC3);

    loop = 1'b1;
    done_q.delete();
    start_tx(8'h96, k);
    wait_pos(k + 3 * C + 3);
    reset = 1'b0;
    #1;
    check("rst_mid_txd", TxD, 1'b1);
    check("rst_mid_txdone", TxDone, 1'b0);
    repeat (3) @(posedge tck);
    #1 reset = 1'b1;
    repeat (2 * C) @(posedge tck);
    #1;
    check("rst_mid_no_done", done_q.size(), 0);
    check("rst_mid_rx", RxData, 8'h00);

    start_tx(8'h69, k);
    wait_neg(k + FRAME + 2);
    check("post_rst_rx", RxData, 8'h69);
    check("post_rst_done_count", done_q.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
